// File: rtl/mux16_to_1_pkg.sv
// -----------------------------------------------------------------------------
// mux16_to_1_pkg
// Shared constants and types for the registered 16:1 lane selector.
//   LANES       : number of input lanes
//   SEL_W       : width of the lane index
//   GROUP       : lanes per first-stage 4:1 mux
//   GROUP_SEL_W : width of the select feeding one 4:1 mux
//   NUM_GROUPS  : number of first-stage muxes
//   lane_idx_t  : unsigned lane index 0..LANES-1 (for the bench and any parent)
// -----------------------------------------------------------------------------
package mux16_to_1_pkg;

    localparam int LANES       = 16;
    localparam int SEL_W       = 4;
    localparam int GROUP       = 4;
    localparam int GROUP_SEL_W = 2;
    localparam int NUM_GROUPS  = LANES / GROUP;

    typedef logic [SEL_W-1:0] lane_idx_t;

endpackage : mux16_to_1_pkg

// File: rtl/mux4_1.sv
// -----------------------------------------------------------------------------
// mux4_1
// Purely combinational 4:1 multiplexer, WIDTH bits per lane.
//   in  [0:3] : four lanes, in[0] is the most-significant slice of the bus
//   sel [0:1] : lane index, sel[0] is the MSB
//   out       : selected lane
// Only the addressed lane is read, so X on any other lane cannot reach out.
// -----------------------------------------------------------------------------
module mux4_1
    import mux16_to_1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [0:GROUP-1][WIDTH-1:0] in,
    input  logic [0:GROUP_SEL_W-1]      sel,
    output logic [WIDTH-1:0]            out
);

    // Lane selection; the default arm only covers non-binary select values.
    always_comb begin
        out = {WIDTH{1'b0}};
        case (sel)
            2'd0:    out = in[0];
            2'd1:    out = in[1];
            2'd2:    out = in[2];
            2'd3:    out = in[3];
            default: out = {WIDTH{1'b0}};
        endcase
    end

endmodule : mux4_1

// File: rtl/mux16_to_1.sv
// -----------------------------------------------------------------------------
// mux16_to_1
// Registered 16:1 lane selector built as a two-level tree of 4:1 muxes.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in        : sixteen WIDTH-bit lanes, lane 0 is the most-significant slice
//   sel [0:3] : unsigned lane index, sel[0] is the MSB
//   in_valid  : in/sel are sampled when high
//   out       : registered selected lane (holds while in_valid is low)
//   out_valid : registered copy of in_valid
// Latency is one clock; one selection per cycle.
// -----------------------------------------------------------------------------
module mux16_to_1
    import mux16_to_1_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [0:LANES-1][WIDTH-1:0] in,
    input  logic [0:SEL_W-1]            sel,
    input  logic                        in_valid,
    output logic [WIDTH-1:0]            out,
    output logic                        out_valid
);

    // Lanes regrouped per first-stage mux: group g holds lanes 4g..4g+3.
    logic [0:GROUP-1][WIDTH-1:0] grp_in_s [NUM_GROUPS];
    // Stage-1 results, one per group, indexed by group number.
    logic [0:NUM_GROUPS-1][WIDTH-1:0] grp_out_s;
    // Stage-2 result: the combinationally selected lane.
    logic [WIDTH-1:0] sel_lane_s;

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic             out_valid_d;
    logic             out_valid_q;

    // Stage 1: the two select LSBs pick a lane within every group.
    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_stage1
        for (genvar j = 0; j < GROUP; j++) begin : g_lane
            assign grp_in_s[g][j] = in[GROUP*g + j];
        end

        mux4_1 #(
            .WIDTH (WIDTH)
        ) u_mux_s1 (
            .in  (grp_in_s[g]),
            .sel (sel[2:3]),
            .out (grp_out_s[g])
        );
    end

    // Stage 2: the two select MSBs pick the group.
    mux4_1 #(
        .WIDTH (WIDTH)
    ) u_mux_s2 (
        .in  (grp_out_s),
        .sel (sel[0:1]),
        .out (sel_lane_s)
    );

    // Next-state: capture the selected lane on valid, otherwise hold it.
    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            out_d       = sel_lane_s;
            out_valid_d = 1'b1;
        end else begin
            out_d       = out_q;
            out_valid_d = 1'b0;
        end
    end

    // Output register with immediate clear on reset assertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule : mux16_to_1

// File: tb/tb_mux16_to_1.sv
// -----------------------------------------------------------------------------
// tb_mux16_to_1
// Bench for mux16_to_1 at WIDTH=1 and WIDTH=8 sharing clock, reset, sel and
// in_valid. A lane-picking reference (shift of the flattened bus) predicts
// both outputs every cycle; directed phases add literal expectations.
// -----------------------------------------------------------------------------
module tb_mux16_to_1;
    import mux16_to_1_pkg::*;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b1;
    logic [0:15]         in1;
    logic [0:15][7:0]    in8;
    lane_idx_t           sel;
    logic                in_valid;
    logic                out1;
    logic                ov1;
    logic [7:0]          out8;
    logic                ov8;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    // Reference state
    logic       exp1  = 1'b0;
    logic [7:0] exp8  = 8'h00;
    logic       expv  = 1'b0;

    always #5 clk = ~clk;

    mux16_to_1 #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in1),
        .sel       (sel),
        .in_valid  (in_valid),
        .out       (out1),
        .out_valid (ov1)
    );

    mux16_to_1 #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in8),
        .sel       (sel),
        .in_valid  (in_valid),
        .out       (out8),
        .out_valid (ov8)
    );

    // Lane s of a 16-bit bus whose lane 0 is bit 15.
    function automatic logic pick1(logic [15:0] bus, int s);
        logic [15:0] t;
        t = bus >> (15 - s);
        return t[0];
    endfunction

    // Lane s of a 128-bit bus whose lane 0 is bits 127:120.
    function automatic logic [7:0] pick8(logic [127:0] bus, int s);
        logic [127:0] t;
        t = bus >> (8 * (15 - s));
        return t[7:0];
    endfunction

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: capture on valid, hold otherwise, clear on reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp1 <= 1'b0;
            exp8 <= 8'h00;
            expv <= 1'b0;
        end else begin
            if (in_valid) begin
                exp1 <= pick1(in1, int'(sel));
                exp8 <= pick8(in8, int'(sel));
            end
            expv <= in_valid;
        end
    end

    // Every-cycle comparison against the reference.
    always @(negedge clk) begin
        if (checking) begin
            cmp("model_out1", {7'h00, out1}, {7'h00, exp1});
            cmp("model_ov1",  {7'h00, ov1},  {7'h00, expv});
            cmp("model_out8", out8,          exp8);
            cmp("model_ov8",  {7'h00, ov8},  {7'h00, expv});
        end
    end

    task automatic rand_in8();
        for (int l = 0; l < 16; l++) in8[l] = 8'($urandom);
    endtask

    task automatic drive(input logic [15:0] i1, input int s, input logic v);
        @(posedge clk);
        #1;
        in1      = i1;
        sel      = lane_idx_t'(s);
        in_valid = v;
        rand_in8();
    endtask

    // Drive one vector and check the WIDTH=1 output just after the capture.
    task automatic dcheck(input logic [15:0] i1, input int s, input string name, input logic e);
        drive(i1, s, 1'b1);
        @(posedge clk);
        #1;
        cmp(name, {7'h00, out1}, {7'h00, e});
        cmp({name, "_v"}, {7'h00, ov1}, 8'h01);
    endtask

    initial begin
        logic [15:0] pat;
        in1      = 16'hFFFF;
        sel      = 4'd5;
        in_valid = 1'b1;
        rand_in8();
        checking = 1'b1;
        #1 rst_n = 1'b0;

        // Reset held with active-looking inputs
        repeat (3) begin
            @(negedge clk);
            cmp("rst_out1", {7'h00, out1}, 8'h00);
            cmp("rst_ov1",  {7'h00, ov1},  8'h00);
            cmp("rst_out8", out8,          8'h00);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Walking one, back to back
        for (int k = 0; k < 16; k++) begin
            drive(16'h8000 >> k, k, 1'b1);
            @(negedge clk);
            if (k > 0) begin
                cmp("walk1", {7'h00, out1}, 8'h01);
                cmp("walk1_v", {7'h00, ov1}, 8'h01);
            end
        end
        @(negedge clk);
        cmp("walk1_last", {7'h00, out1}, 8'h01);

        // Lane/select mismatch
        dcheck(16'b1000_0000_0000_0000, 15, "mis_lane0", 1'b0);
        dcheck(16'b0000_0000_0000_0001, 15, "mis_lane15", 1'b1);

        // Walking zero with neighbours
        for (int k = 0; k < 16; k++) begin
            pat = ~(16'h8000 >> k);
            dcheck(pat, k, "walk0", 1'b0);
            if (k > 0)  dcheck(pat, k - 1, "walk0_lo", 1'b1);
            if (k < 15) dcheck(pat, k + 1, "walk0_hi", 1'b1);
        end

        // Hold while in_valid is low
        dcheck(16'h2000, 2, "hold_cap", 1'b1);
        drive(16'h0000, 2, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            cmp("hold_out", {7'h00, out1}, 8'h01);
            cmp("hold_v",   {7'h00, ov1},  8'h00);
        end
        dcheck(16'h0000, 2, "hold_upd", 1'b0);

        // WIDTH=8 descending sweep, no bubbles
        for (int s = 15; s >= 0; s--) begin
            @(posedge clk);
            #1;
            for (int l = 0; l < 16; l++) in8[l] = 8'(8'h10 + l);
            in1      = 16'($urandom);
            sel      = lane_idx_t'(s);
            in_valid = 1'b1;
            @(negedge clk);
            if (s < 15) begin
                cmp("sweep8", out8, 8'(8'h10 + s + 1));
                cmp("sweep8_v", {7'h00, ov8}, 8'h01);
            end
        end
        @(negedge clk);
        cmp("sweep8_last", out8, 8'h10);

        // Asynchronous reset between edges
        drive(16'hFFFF, 3, 1'b1);
        @(posedge clk);
        #1;
        cmp("pre_rst", {7'h00, out1}, 8'h01);
        #1 rst_n = 1'b0;
        #1;
        cmp("arst_out1", {7'h00, out1}, 8'h00);
        cmp("arst_ov1",  {7'h00, ov1},  8'h00);
        cmp("arst_out8", out8,          8'h00);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Randomized traffic, some with X on unselected lanes
        repeat (400) begin
            @(posedge clk);
            #1;
            in1      = 16'($urandom);
            sel      = lane_idx_t'($urandom_range(0, 15));
            in_valid = ($urandom_range(0, 3) != 0);
            rand_in8();
            if ($urandom_range(0, 4) == 0) begin
                for (int l = 0; l < 16; l++) begin
                    if (l != int'(sel) && $urandom_range(0, 1) == 1) begin
                        in1[l] = 1'bx;
                        in8[l] = 8'hxx;
                    end
                end
            end
        end
        @(negedge clk);
        @(negedge clk);
        checking = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mux16_to_1

// File: doc/mux16_to_1.md
# mux16_to_1

Registered 16:1 selector that routes one of sixteen input lanes to a single output lane under a 4-bit select. Built as a two-level tree of 4:1 muxes: four first-stage muxes and one second-stage mux. The result is captured in an output register, giving a clean one-cycle-latency selection stage for datapath steering and bit-select logic. The output is qualified by a valid strobe.

## Interface
- WIDTH, default 1: bits per input lane and of the output.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  16×WIDTH  sixteen lanes, indexed 0..15. Lane 0 is the most-significant slice of the bus (ascending index [0:15] when WIDTH=1), so the literal 16'b1000_0000_0000_0000 drives lane 0.
- sel  input  4  unsigned lane index 0..15, declared ascending [0:3] with sel[0] as MSB; 4'b0001 selects lane 1.
- in_valid  input  1  asserted when in/sel are to be sampled.
- out  output  WIDTH  registered selected lane.
- out_valid  output  1  registered copy of in_valid.

## Operation
- Combinational select is in[sel]. The lane whose index equals the unsigned value of sel is passed through. Every sel value 0..15 is legal, so there is no out-of-range case.
- First stage: four mux4 instances, group g covering lanes 4g..4g+3. Each selects with sel[2:3] (the two LSBs, value 0..3).
- Second stage: one mux4 instance selects group sel[0:1].
- Output register:
  - On a clk rising edge with in_valid=1, out <= in[sel] and out_valid <= 1.
  - With in_valid=0, out holds its previous value and out_valid <= 0.
- No other state. There is no FSM.
- Unselected lanes never affect out. X on an unselected lane must not propagate.

## Timing
- Latency is exactly one clock from sampling in/sel/in_valid to out/out_valid.
- Throughput is one selection per cycle. Back-to-back valid inputs produce back-to-back valid outputs.
- Reset values: out = 0 (all WIDTH bits), out_valid = 0.
  - Reset takes effect immediately on rst_n falling, independent of clk.
  - Release is synchronous in effect: the first capture occurs on the first rising edge with rst_n=1.
- Reset mid-stream: any in-flight selection is discarded. Outputs show reset values until a valid capture after release.
- Simultaneous sel and in change in the same cycle: the registered result uses both new values. There is no mixing of old sel with new in.
- in/sel must be stable for setup/hold around the rising edge. The combinational tree depth is two mux4 levels.

## Structure
- Shared package holds:
  - LANES = 16
  - SEL_W = 4
  - GROUP = 4
  - a lane-index typedef (logic [SEL_W-1:0]) used by the bench and any parent.
- One sub-module, mux4_1: purely combinational 4:1 mux, parameterised on WIDTH, with ports in[0:3], sel[0:1] and out. It is instantiated five times.
- The top holds the generate loop for stage 1, the stage-2 instance and the output register.

## Test plan
- Reset: hold rst_n=0 with in=16'hFFFF, sel=5 and in_valid=1 for 3 cycles -> out=0 and out_valid=0 throughout. Assert rst_n=0 asynchronously mid-cycle and check outputs clear before the next edge.
- Walking one: for k=0..15, drive in with only lane k set (k=0 -> 16'b1000…0, k=15 -> 16'b0…01) and sel=k, in_valid=1 each cycle -> out=1 and out_valid=1 one cycle later, every cycle.
- Mismatch: in=16'b1000_0000_0000_0000 (lane 0 set) with sel=4'b1111 -> out=0. Then in=16'b0000_0000_0000_0001 with sel=4'b1111 -> out=1.
- Walking zero: in=all ones except lane k, sel=k -> out=0. Also sel=k±1 -> out=1 for every k.
- Hold: capture sel=2 with in lane 2=1, then drop in_valid and change in to 0 -> out stays 1 and out_valid=0. Raise in_valid -> out updates next cycle.
- WIDTH=8: in lanes = 8'h10+k, sel sweeping 15 down to 0 back-to-back -> out = 8'h1F..8'h10 with one-cycle latency and no bubbles.
